// File: rtl/snn_config_sequencer.sv
// Streams per-core parameter words, then neuron instructions, into the SNN grid under FIFO-full
// backpressure, and waits for the grid's per-core acknowledge before moving to the next core.
module snn_config_sequencer #(
  parameter int unsigned NUM_CORES  = 6,
  parameter int unsigned NEURONS    = 256,
  parameter int unsigned INST_COUNT = 256,
  parameter int unsigned PARAM_W    = 368,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               src_param_valid,
  input  logic [PARAM_W-1:0] src_param_data,
  output logic               src_param_ready,
  input  logic               src_inst_valid,
  input  logic [1:0]         src_inst_data,
  output logic               src_inst_ready,
  input  logic               param_wfull,
  input  logic               neuron_inst_wfull,
  input  logic               next_core_en,
  output logic [PARAM_W-1:0] parameter_in,
  output logic               param_winc,
  output logic [1:0]         neuron_inst_wdata,
  output logic               neuron_inst_winc,
  output logic [2:0]         next_core,
  output logic               busy,
  output logic               config_done,
  output logic               config_error
);

  localparam int unsigned PcntW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int unsigned IcntW = (INST_COUNT > 1) ? $clog2(INST_COUNT) : 1;
  localparam int unsigned TcntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PcntW-1:0] PcntLast = PcntW'(NEURONS - 1);
  localparam logic [IcntW-1:0] IcntLast = IcntW'(INST_COUNT - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);
  localparam logic [2:0]       CoreLast = 3'(NUM_CORES - 1);
  localparam logic [2:0]       CoreNone = 3'd7;

  typedef enum logic [2:0] {
    StIdle, StLoadParam, StLoadInst, StWaitCore, StDone, StError
  } state_e;

  state_e           state_q, state_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [IcntW-1:0] icnt_q, icnt_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [2:0]       core_q, core_d;

  // Handshakes are combinational on the full flags so a full FIFO never costs a write.
  assign src_param_ready   = (state_q == StLoadParam) & ~param_wfull;
  assign param_winc        = src_param_ready & src_param_valid;
  assign src_inst_ready    = (state_q == StLoadInst) & ~neuron_inst_wfull;
  assign neuron_inst_winc  = src_inst_ready & src_inst_valid;
  assign parameter_in      = src_param_data;
  assign neuron_inst_wdata = src_inst_data;

  assign next_core    = core_q;
  assign busy         = (state_q == StLoadParam) | (state_q == StLoadInst) |
                        (state_q == StWaitCore);
  assign config_done  = (state_q == StDone);
  assign config_error = (state_q == StError);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    icnt_d  = icnt_q;
    tcnt_d  = tcnt_q;
    core_d  = core_q;
    if (abort) begin
      state_d = StIdle;
      core_d  = CoreNone;
      pcnt_d  = '0;
      icnt_d  = '0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_d = StLoadParam;
            core_d  = 3'd0;
            pcnt_d  = '0;
            icnt_d  = '0;
            tcnt_d  = '0;
          end
        end
        StLoadParam: begin
          if (param_winc) begin
            if (pcnt_q == PcntLast) begin
              pcnt_d  = '0;
              state_d = StLoadInst;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
        StLoadInst: begin
          if (neuron_inst_winc) begin
            if (icnt_q == IcntLast) begin
              icnt_d  = '0;
              tcnt_d  = '0;
              state_d = StWaitCore;
            end else begin
              icnt_d = icnt_q + 1'b1;
            end
          end
        end
        StWaitCore: begin
          // Acknowledge only counts once we are actually waiting; earlier highs are stale.
          if (next_core_en) begin
            if (core_q == CoreLast) begin
              state_d = StDone;
              core_d  = CoreNone;
            end else begin
              state_d = StLoadParam;
              core_d  = core_q + 1'b1;
            end
          end else if (tcnt_q == TcntLast) begin
            state_d = StError;
            core_d  = CoreNone;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          core_d  = CoreNone;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      icnt_q  <= '0;
      tcnt_q  <= '0;
      core_q  <= CoreNone;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      icnt_q  <= icnt_d;
      tcnt_q  <= tcnt_d;
      core_q  <= core_d;
    end
  end

endmodule

// File: tb/tb_snn_config_sequencer.sv
// Bench for snn_config_sequencer: a cycle vector table, full loads under random stimulus checked
// against a write-sequence model, and hand-written timeout / abort / reset sequences.
module tb_snn_config_sequencer;

  localparam int unsigned NUM_CORES  = 6;
  localparam int unsigned NEURONS    = 4;
  localparam int unsigned INST_COUNT = 3;
  localparam int unsigned PARAM_W    = 368;
  localparam int unsigned TIMEOUT    = 8;
  localparam int unsigned TOTAL_P    = NUM_CORES * NEURONS;
  localparam int unsigned TOTAL_I    = NUM_CORES * INST_COUNT;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start, abort;
  logic               src_param_valid, src_param_ready;
  logic [PARAM_W-1:0] src_param_data;
  logic               src_inst_valid, src_inst_ready;
  logic [1:0]         src_inst_data;
  logic               param_wfull, neuron_inst_wfull, next_core_en;
  logic [PARAM_W-1:0] parameter_in;
  logic               param_winc, neuron_inst_winc;
  logic [1:0]         neuron_inst_wdata;
  logic [2:0]         next_core;
  logic               busy, config_done, config_error;

  int total = 0;
  int bad   = 0;

  snn_config_sequencer #(
    .NUM_CORES (NUM_CORES),
    .NEURONS   (NEURONS),
    .INST_COUNT(INST_COUNT),
    .PARAM_W   (PARAM_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .src_param_valid  (src_param_valid),
    .src_param_data   (src_param_data),
    .src_param_ready  (src_param_ready),
    .src_inst_valid   (src_inst_valid),
    .src_inst_data    (src_inst_data),
    .src_inst_ready   (src_inst_ready),
    .param_wfull      (param_wfull),
    .neuron_inst_wfull(neuron_inst_wfull),
    .next_core_en     (next_core_en),
    .parameter_in     (parameter_in),
    .param_winc       (param_winc),
    .neuron_inst_wdata(neuron_inst_wdata),
    .neuron_inst_winc (neuron_inst_winc),
    .next_core        (next_core),
    .busy             (busy),
    .config_done      (config_done),
    .config_error     (config_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start, abort, pv, pf, iv, ifull, ack;
    logic [3:0] comb;   // {param_ready, param_winc, inst_ready, inst_winc} before the edge
    logic [5:0] post;   // {next_core, busy, config_done, config_error} after the edge
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [PARAM_W-1:0] act,
                     input logic [PARAM_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0; abort = 1'b0;
    src_param_valid = 1'b0; src_param_data = '0;
    src_inst_valid = 1'b0; src_inst_data = '0;
    param_wfull = 1'b0; neuron_inst_wfull = 1'b0; next_core_en = 1'b0;
  endtask

  function automatic logic [3:0] hs();
    return {src_param_ready, param_winc, src_inst_ready, neuron_inst_winc};
  endfunction

  // Full load of all cores; the model tracks which word is due next and when a core waits.
  task automatic run_load(input int ack_delay, input bit stress, input bit stale, input string tag);
    logic [PARAM_W-1:0] params [TOTAL_P];
    logic [1:0]         insts  [TOTAL_I];
    int   pw_cnt, iw_cnt, obs_pw, obs_iw, m_core, m_wait, cyc;
    bit   m_waiting, in_param, in_inst;
    logic [3:0] exp_c;
    for (int i = 0; i < TOTAL_P; i++) begin
      params[i] = '0;
      for (int k = 0; k < 12; k++) params[i] = {params[i][PARAM_W-33:0], 32'($urandom)};
    end
    for (int i = 0; i < TOTAL_I; i++) insts[i] = 2'($urandom);
    pw_cnt = 0; iw_cnt = 0; obs_pw = 0; obs_iw = 0;
    m_core = 0; m_wait = 0; m_waiting = 0; cyc = 0;
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_start_core"}, next_core, 0);
    while (m_core < NUM_CORES && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      src_param_valid = (pw_cnt < TOTAL_P) && (!stress || $urandom_range(0, 3) != 0);
      if (pw_cnt < TOTAL_P) src_param_data = params[pw_cnt];
      src_inst_valid = (iw_cnt < TOTAL_I) && (!stress || $urandom_range(0, 3) != 0);
      if (iw_cnt < TOTAL_I) src_inst_data = insts[iw_cnt];
      param_wfull       = stress && ($urandom_range(0, 2) == 0);
      neuron_inst_wfull = stress && ($urandom_range(0, 2) == 0);
      next_core_en      = stale || (m_waiting && m_wait == ack_delay);
      #1;
      in_param = !m_waiting && (pw_cnt < (m_core + 1) * NEURONS);
      in_inst  = !m_waiting && !in_param;
      exp_c = {in_param && !param_wfull, in_param && src_param_valid && !param_wfull,
               in_inst && !neuron_inst_wfull, in_inst && src_inst_valid && !neuron_inst_wfull};
      chk({tag, "_handshake"}, hs(), exp_c);
      if (exp_c[2]) begin
        chk({tag, "_param_data"}, parameter_in, params[pw_cnt]);
        chk({tag, "_param_core"}, next_core, pw_cnt / NEURONS);
      end
      if (exp_c[0]) begin
        chk({tag, "_inst_data"}, neuron_inst_wdata, insts[iw_cnt]);
        chk({tag, "_inst_core"}, next_core, iw_cnt / INST_COUNT);
      end
      obs_pw += int'(param_winc);
      obs_iw += int'(neuron_inst_winc);
      if (exp_c[2]) pw_cnt++;
      if (exp_c[0]) begin
        iw_cnt++;
        if (iw_cnt % INST_COUNT == 0) begin
          m_waiting = 1'b1;
          m_wait    = 0;
        end
      end else if (m_waiting) begin
        if (next_core_en) begin
          m_waiting = 1'b0;
          m_core++;
        end else begin
          m_wait++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      chk({tag, "_next_core"}, next_core, (m_core == NUM_CORES) ? 7 : m_core);
    end
    chk({tag, "_finished"}, m_core, NUM_CORES);
    chk({tag, "_param_strobes"}, obs_pw, TOTAL_P);
    chk({tag, "_inst_strobes"}, obs_iw, TOTAL_I);
    chk({tag, "_done_status"}, {busy, config_done, config_error}, 3'b010);
    if (stale && !stress)
      chk({tag, "_edges_to_done"}, cyc, NUM_CORES * (NEURONS + INST_COUNT + 1));
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // start abort pv pf iv if ack | comb | {core, busy, done, err}
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {3'd7, 3'b000}};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {3'd0, 3'b100}};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, {3'd0, 3'b100}};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, {3'd0, 3'b100}};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, {3'd0, 3'b100}};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, {3'd0, 3'b100}};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, {3'd0, 3'b100}};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, {3'd0, 3'b100}};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, {3'd0, 3'b100}};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'b100}};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'b100}};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, {3'd0, 3'b100}};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {3'd0, 3'b100}};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, {3'd1, 3'b100}};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, {3'd7, 3'b000}};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, {3'd7, 3'b000}};

    clear_inputs();
    reset_n = 1'b0;
    #23;
    chk("reset_core", next_core, 7);
    chk("reset_status", {busy, config_done, config_error}, 3'b000);
    chk("reset_handshake", hs(), 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = vecs[i].start; abort = vecs[i].abort;
      src_param_valid = vecs[i].pv; param_wfull = vecs[i].pf;
      src_inst_valid = vecs[i].iv; neuron_inst_wfull = vecs[i].ifull;
      next_core_en = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_handshake", i), hs(), vecs[i].comb);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_status", i), {next_core, busy, config_done, config_error},
          vecs[i].post);
    end
    @(negedge clk);
    clear_inputs();

    run_load(2, 1'b0, 1'b0, "nominal");
    for (int r = 0; r < 3; r++) run_load($urandom_range(0, 5), 1'b1, 1'b0, "backpressure");
    run_load(0, 1'b0, 1'b1, "stale");
    run_load(0, 1'b1, 1'b1, "stale_bp");

    // Timeout: load core 0 with no stalls, then hold the acknowledge low.
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0; src_param_valid = 1'b1; src_inst_valid = 1'b1;
    repeat (NEURONS + INST_COUNT) @(posedge clk);
    #1;
    n = 0;
    while (!config_error && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_edges", n, TIMEOUT);
    chk("timeout_core", next_core, 7);
    chk("timeout_status", {busy, config_done, config_error}, 3'b001);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("restart_core", next_core, 0);
    chk("restart_status", {busy, config_done, config_error}, 3'b100);
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_from_load", {next_core, busy}, {3'd7, 1'b0});

    // Abort in core 2 after its first instruction write, acknowledge held high throughout.
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0; src_param_valid = 1'b1; src_inst_valid = 1'b1; next_core_en = 1'b1;
    repeat (2 * (NEURONS + INST_COUNT + 1) + NEURONS + 1) @(posedge clk);
    @(negedge clk); #1;
    chk("abort_pre_core", next_core, 2);
    chk("abort_pre_handshake", hs(), 4'b0011);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_core", next_core, 7);
    chk("abort_status", {busy, config_done, config_error}, 3'b000);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_handshake", hs(), 4'b0000);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    chk("start_with_abort", {next_core, busy}, {3'd7, 1'b0});

    // Asynchronous reset between edges while loading parameters.
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0; src_param_valid = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_core", next_core, 7);
    chk("async_reset_status", {busy, config_done, config_error}, 3'b000);
    chk("async_reset_handshake", hs(), 4'b0000);
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {next_core, busy, src_param_ready}, {3'd7, 1'b0, 1'b0});
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_start", {next_core, busy}, {3'd0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_config_sequencer.md
# snn_config_sequencer

Configuration sequencer for the SNN 3x2 grid's parameter and neuron-instruction load path. It pulls parameter words and 2-bit neuron instructions from a streaming source (CPU-side DMA or ROM reader) and presents them to the grid one core at a time. It drives `next_core`, `param_winc` and `neuron_inst_winc` under the grid's FIFO-full backpressure, then waits for the grid's `next_core_en` acknowledge before advancing to the next core. It sits between the configuration source and the grid's configuration ports, in the `clk` domain.

## Interface
- NUM_CORES, 6, number of cores loaded, indices 0..NUM_CORES-1 (max 7)
- NEURONS, 256, parameter words per core
- INST_COUNT, 256, neuron-instruction words per core
- PARAM_W, 368, parameter word width
- TIMEOUT, 1024, max cycles spent in WAIT_CORE before error (≥2)

- clk  in  1  SNN clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a full load
- abort  in  1  single-cycle pulse; returns to IDLE
- src_param_valid  in  1  source parameter word valid
- src_param_data  in  PARAM_W  source parameter word
- src_param_ready  out  1  parameter word accepted this cycle when valid is also high
- src_inst_valid  in  1  source instruction valid
- src_inst_data  in  2  source instruction
- src_inst_ready  out  1  instruction accepted this cycle when valid is also high
- param_wfull  in  1  grid parameter FIFO full
- neuron_inst_wfull  in  1  grid instruction FIFO full
- next_core_en  in  1  grid acknowledge: current core's configuration has been consumed
- parameter_in  out  PARAM_W  to grid; equals src_param_data
- param_winc  out  1  to grid; parameter write strobe
- neuron_inst_wdata  out  2  to grid; equals src_inst_data
- neuron_inst_winc  out  1  to grid; instruction write strobe
- next_core  out  3  registered index of the core being loaded; 3'd7 when no core is selected
- busy  out  1  state is not IDLE, DONE or ERROR
- config_done  out  1  state is DONE
- config_error  out  1  state is ERROR

## Operation
- States: IDLE, LOAD_PARAM, LOAD_INST, WAIT_CORE, DONE, ERROR.
- IDLE, DONE, ERROR:
  - `start` → LOAD_PARAM, `next_core` ← 0, counters cleared.
  - Otherwise the state holds.
- LOAD_PARAM:
  - `src_param_ready = !param_wfull`; `param_winc = src_param_valid & !param_wfull`.
  - Each write increments `pcnt`.
  - On the write with `pcnt == NEURONS-1`: `pcnt` ← 0, go to LOAD_INST.
- LOAD_INST:
  - `src_inst_ready = !neuron_inst_wfull`; `neuron_inst_winc = src_inst_valid & !neuron_inst_wfull`.
  - On the write with `icnt == INST_COUNT-1`: `icnt` ← 0, go to WAIT_CORE, `tcnt` ← 0.
- WAIT_CORE:
  - `next_core_en` = 1 with `next_core == NUM_CORES-1` → DONE, `next_core` ← 7.
  - `next_core_en` = 1 otherwise → `next_core` ← `next_core` + 1, go to LOAD_PARAM.
  - `next_core_en` = 0 with `tcnt == TIMEOUT-1` → ERROR, `next_core` ← 7.
  - Otherwise `tcnt` increments.
- `abort`, in any state → IDLE, `next_core` ← 7, counters cleared. `abort` has priority over `start` and over every other transition in the same cycle.
- Ready and strobe outputs are 0 in every state except the one that owns them. Data outputs are combinational pass-through; the grid samples them only when the strobe is high.
- Counter widths are `$clog2` of the terminal value, minimum 1 bit. Counters never wrap within a state.
- A `next_core_en` that is high before WAIT_CORE is entered is ignored, including one already high on the entry cycle's predecessor. Only samples taken while in WAIT_CORE count.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `next_core` = 7, all counters 0, `busy` = `config_done` = `config_error` = 0, all strobes and readies 0.
- `start` sampled at edge n → LOAD_PARAM and `next_core` = 0 visible after edge n; the first write can occur in cycle n+1.
- Throughput is one word per cycle with no bubbles between consecutive words, including across the LOAD_PARAM→LOAD_INST boundary.
- Full-flag backpressure is combinational: a cycle with the FIFO full produces no strobe and no ready.
- The last instruction write and WAIT_CORE entry happen on the same edge. The earliest core advance is the following edge, if `next_core_en` = 1.
- Timeout: with `next_core_en` held 0, ERROR is entered on the TIMEOUT-th edge after WAIT_CORE entry.
- Status outputs are combinational decodes of the registered state; `next_core` is registered.

## Test plan
- Nominal load (NEURONS=4, INST_COUNT=3, NUM_CORES=6): source always valid, FIFOs never full, `next_core_en` pulsed 2 cycles after each WAIT_CORE entry → exactly 24 `param_winc` and 18 `neuron_inst_winc` strobes; `next_core` steps 0..5, then 7; `config_done` = 1; data order preserved.
- Backpressure: toggle `param_wfull` and `neuron_inst_wfull` randomly, source valid randomly → no strobe while full, no word lost or duplicated, strobe count unchanged.
- Timeout (TIMEOUT=8): hold `next_core_en` = 0 → ERROR exactly 8 edges after WAIT_CORE entry; `config_error` = 1; `next_core` = 7; a later `start` restarts at core 0.
- Abort: pulse `abort` mid-LOAD_INST on core 2 → IDLE next edge, strobes 0, `next_core` = 7; `start` together with `abort` → remains IDLE.
- Stale acknowledge: hold `next_core_en` = 1 throughout → each core still receives the full NEURONS and INST_COUNT words, and each core advance occurs 1 edge after WAIT_CORE entry.
- Async reset asserted mid-LOAD_PARAM, between clock edges → outputs immediately at reset values; after release, IDLE until `start`.
